// File: rtl/exec_alu_seq.sv
// exec_alu_seq
// Execute-stage ALU. Logic, arithmetic and compare operations produce a
// registered result one cycle after acceptance. Shifts run on an iterative
// one-bit-per-cycle shifter; busy is raised to the hazard unit while a shift
// is in progress.
//
// Handshake: an operation transfers on a rising edge when
// in_valid && in_ready && !flush. in_ready is high only in IDLE; upstream
// must hold the operation stable until it is accepted. out_valid pulses for
// one cycle per completed operation (back-to-back completions keep it high).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operation handshake
//   alusel            4-bit operation code
//   op_a, op_b        operands; op_b[SHW-1:0] is the shift amount
//   flush             synchronous kill of any in-flight operation
//   out_valid         result holds a newly completed operation
//   result, zero      registered result and (result == 0)
//   busy              high while a shift is iterating
//   state_dbg         current FSM state (0 = IDLE, 1 = SHIFT)
module exec_alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alusel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic [0:0]      state_dbg
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  logic [0:0]      state;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
  logic [1:0]      kind;

  logic            accept;
  logic            is_shift;
  logic [1:0]      dec_kind;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_value;
  logic [XLEN-1:0] acc_next;

  assign shamt     = op_b[SHW-1:0];
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_SHIFT);
  assign zero      = (result == '0);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready && !flush;

  // Decode: which codes are shifts, and which shift flavour they are.
  always_comb begin
    is_shift = 1'b0;
    dec_kind = K_SLL;
    case (alusel)
      4'b0011, 4'b0100: begin is_shift = 1'b1; dec_kind = K_SLL; end
      4'b1000, 4'b0101: begin is_shift = 1'b1; dec_kind = K_SRL; end
      4'b1100:          begin is_shift = 1'b1; dec_kind = K_SRA; end
      default:          begin is_shift = 1'b0; dec_kind = K_SLL; end
    endcase
  end

  // Single-cycle result. A shift reaching this path has shamt 0, which
  // passes op_a through unchanged.
  always_comb begin
    alu_value = '0;
    case (alusel)
      4'b0010: alu_value = op_a + op_b;
      4'b0110: alu_value = op_a - op_b;
      4'b0000: alu_value = op_a & op_b;
      4'b0001: alu_value = op_a | op_b;
      4'b1001: alu_value = op_a ^ op_b;
      4'b0111: alu_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1111: alu_value = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_value = is_shift ? op_a : '0;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    acc_next = acc;
    case (kind)
      K_SLL:   acc_next = {acc[XLEN-2:0], 1'b0};
      K_SRL:   acc_next = {1'b0, acc[XLEN-1:1]};
      K_SRA:   acc_next = {acc[XLEN-1], acc[XLEN-1:1]};
      default: acc_next = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      kind      <= K_SLL;
    end else if (flush) begin
      // Kill wins over everything; result keeps its last completed value.
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              acc       <= op_a;
              cnt       <= shamt;
              kind      <= dec_kind;
              out_valid <= 1'b0;
              state     <= ST_SHIFT;
            end else begin
              result    <= alu_value;
              out_valid <= 1'b1;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        ST_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - {{(SHW-1){1'b0}}, 1'b1};
          if (cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
            result    <= acc_next;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_alu_seq.sv
// Testbench for exec_alu_seq: directed vectors with hand-computed results,
// plus a reference model that derives expected outputs from whole-operation
// arithmetic and a latency count, compared on every falling edge.
module tb_exec_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alusel = 4'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic [0:0]  state_dbg;

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  exec_alu_seq #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alusel(alusel), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .result(result), .zero(zero), .busy(busy),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_is_shift(input logic [3:0] sel);
    return (sel == 4'b0011) || (sel == 4'b0100) || (sel == 4'b1000) ||
           (sel == 4'b0101) || (sel == 4'b1100);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (sel)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1001: return a ^ b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111: return (a < b) ? 32'd1 : 32'd0;
      4'b0011, 4'b0100: return a << sh;
      4'b1000, 4'b0101: return a >> sh;
      4'b1100: return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  int          m_remaining = 0;  // busy cycles still to go
  logic [31:0] m_result = '0;
  logic [31:0] m_pending = '0;
  logic        m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_remaining = 0;
      m_result    = '0;
      m_valid     = 1'b0;
    end else if (flush) begin
      m_remaining = 0;
      m_valid     = 1'b0;
    end else if (m_remaining > 0) begin
      m_remaining = m_remaining - 1;
      m_valid     = (m_remaining == 0);
      if (m_valid) m_result = m_pending;
    end else if (in_valid) begin
      if (ref_is_shift(alusel) && (op_b[4:0] != 5'd0)) begin
        m_pending   = ref_alu(alusel, op_a, op_b);
        m_remaining = int'(op_b[4:0]);
        m_valid     = 1'b0;
      end else begin
        m_result = ref_alu(alusel, op_a, op_b);
        m_valid  = 1'b1;
      end
    end else begin
      m_valid = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("cmp_busy", {31'b0, busy}, {31'b0, (m_remaining > 0)});
      chk("cmp_in_ready", {31'b0, in_ready}, {31'b0, (m_remaining == 0)});
      chk("cmp_result", result, m_result);
      chk("cmp_zero", {31'b0, zero}, {31'b0, (m_result == 32'd0)});
    end
  end

  // ---------------- driver tasks ----------------
  // Present an op at a falling edge; return at the falling edge after the
  // next rising edge with in_valid still asserted.
  task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alusel   = sel;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for out_valid; returns the number of cycles waited.
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$] = '{
    '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
    '{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
    '{4'b1001, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555},
    '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
    '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
    '{4'b1010, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000},
    '{4'b0101, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000},
    '{4'b1000, 32'h0000_F000, 32'h0000_0104, 32'h0000_0F00},
    '{4'b1100, 32'h7000_0000, 32'h0000_0002, 32'h1C00_0000},
    '{4'b0100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
    '{4'b0011, 32'h0000_00A5, 32'h0000_0003, 32'h0000_0528},
    '{4'b0111, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0000}
  };

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int nbusy;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'b0, zero}, 32'd1);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_en = 1'b1;
    idle(1);

    // add 5+7
    drive(4'b0010, 32'd5, 32'd7);
    chk("add_result", result, 32'd12);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_zero", {31'b0, zero}, 32'd0);
    idle(1);
    chk("add_hold_valid", {31'b0, out_valid}, 32'd0);
    chk("add_hold_result", result, 32'd12);

    // back-to-back sub, slt, sltu
    drive(4'b0110, 32'd3, 32'd3);
    chk("b2b_sub", result, 32'd0);
    chk("b2b_sub_zero", {31'b0, zero}, 32'd1);
    drive(4'b0111, 32'hFFFF_FFFF, 32'd1);
    chk("b2b_slt", result, 32'd1);
    chk("b2b_slt_valid", {31'b0, out_valid}, 32'd1);
    drive(4'b1111, 32'hFFFF_FFFF, 32'd1);
    chk("b2b_sltu", result, 32'd0);
    chk("b2b_sltu_valid", {31'b0, out_valid}, 32'd1);
    idle(1);

    // sra 0x80000000 by 4: four busy cycles, then result
    drive(4'b1100, 32'h8000_0000, 32'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sra_busy", {31'b0, busy}, 32'd1);
      chk("sra_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("sra_valid", {31'b0, out_valid}, 32'd1);
    chk("sra_result", result, 32'hF800_0000);
    chk("sra_ready_back", {31'b0, in_ready}, 32'd1);
    idle(1);

    // srl by max shamt
    drive(4'b1000, 32'h8000_0000, 32'd31);
    in_valid = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
    chk("srl31_busy_cycles", 32'(nbusy), 32'd31);
    chk("srl31_valid", {31'b0, out_valid}, 32'd1);
    chk("srl31_result", result, 32'h0000_0001);
    idle(1);

    // sll by 0 completes in one cycle without busy
    drive(4'b0100, 32'h0000_0001, 32'd0);
    chk("sll0_busy", {31'b0, busy}, 32'd0);
    chk("sll0_valid", {31'b0, out_valid}, 32'd1);
    chk("sll0_result", result, 32'h0000_0001);
    idle(1);

    // sll by 8 flushed on its 3rd busy cycle; an op presented then is dropped
    drive(4'b0011, 32'h0000_0001, 32'd8);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    in_valid = 1'b1;
    alusel = 4'b0010;
    op_a = 32'd9;
    op_b = 32'd9;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_result", result, 32'h0000_0001);
    drive(4'b0010, 32'd2, 32'd3);
    chk("post_flush_add", result, 32'd5);
    chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
    // flush in IDLE drops the op presented with it
    flush = 1'b1;
    alusel = 4'b0010;
    op_a = 32'd1;
    op_b = 32'd1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("idle_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_flush_result", result, 32'd5);
    idle(1);

    // directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].a, vecs[i].b);
      in_valid = 1'b0;
      wait_done("vec", cyc);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
      idle(1);
    end

    // asynchronous reset in the middle of a shift
    drive(4'b0011, 32'd3, 32'd10);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_zero", {31'b0, zero}, 32'd1);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    chk("arst_no_late_valid", {31'b0, out_valid}, 32'd0);
    drive(4'b0010, 32'h10, 32'h20);
    chk("post_reset_add", result, 32'h30);
    idle(2);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $finish;
  end

endmodule
